cpu_control_fsm: RTL and testbench

- Multi-cycle control sequencer for the 16-bit CPU datapath.
- Decodes the 5-bit opcode in Instr[15:11] and the sub-fields, then steps the datapath through fetch, execute and memory phases.
- Drives every datapath mux select, register/PC/LR/flag write enable and the system-bus read/write handshake.
- Owns the interrupt-enable bit and the interrupt entry sequence.

---
 rtl/cpu_control_fsm.sv | 344 ++++++++++++++++++++++++++++++++++
 tb/tb_cpu_control_fsm.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer for the 16-bit CPU: steps the datapath through fetch,
// execute, memory and interrupt-entry phases and drives every select and write enable.
module cpu_control_fsm #(
  parameter int unsigned IW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [IW-1:0] i_instr,
  input  logic [3:0]    i_flags,
  input  logic          i_mem_rdy,
  input  logic          i_int_req,
  output logic          o_mem_read,
  output logic          o_mem_write,
  output logic          o_ir_we,
  output logic          o_pc_we,
  output logic          o_reg_we,
  output logic          o_lr_we,
  output logic          o_flag_we,
  output logic [2:0]    o_pc_sel,
  output logic          o_op1_sel,
  output logic [1:0]    o_op2_sel,
  output logic          o_imm_sel,
  output logic          o_wd_sel,
  output logic [1:0]    o_rs1_sel,
  output logic [1:0]    o_rw_sel,
  output logic          o_lr_sel,
  output logic          o_flag_sel,
  output logic [1:0]    o_alu_or_sel,
  output logic          o_int_ack,
  output logic          o_int_en
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StExec   = 3'd1,
    StMem    = 3'd2,
    StSpUpd  = 3'd3,
    StIntEnt = 3'd4
  } state_e;

  // Select encodings
  localparam logic [2:0] PcOne    = 3'b000;
  localparam logic [2:0] PcAluOut = 3'b001;
  localparam logic [2:0] PcLr     = 3'b011;
  localparam logic [2:0] PcInt    = 3'b111;
  localparam logic       Op1Rd1   = 1'b0;
  localparam logic       Op1Pc    = 1'b1;
  localparam logic [1:0] Op2Imm   = 2'b00;
  localparam logic [1:0] Op2Rd2   = 2'b01;
  localparam logic [1:0] Op2Zero  = 2'b10;
  localparam logic       ImmLong  = 1'b0;
  localparam logic       ImmShort = 1'b1;
  localparam logic       WdAlu    = 1'b0;
  localparam logic       WdSys    = 1'b1;
  localparam logic [1:0] Rs1Rd    = 2'b00;
  localparam logic [1:0] Rs1Seven = 2'b10;
  localparam logic [1:0] RwRd     = 2'b01;
  localparam logic [1:0] RwSeven  = 2'b10;
  localparam logic       LrSys    = 1'b0;
  localparam logic       LrPc     = 1'b1;
  localparam logic       FlagSys  = 1'b0;
  localparam logic       FlagAlu  = 1'b1;
  localparam logic [1:0] AluNone  = 2'b00;
  localparam logic [1:0] AluAdd   = 2'b10;
  localparam logic [1:0] AluSub   = 2'b11;

  // Opcodes
  localparam logic [4:0] OpLdw   = 5'b00000;
  localparam logic [4:0] OpPop   = 5'b00001;
  localparam logic [4:0] OpAdd   = 5'b00010;
  localparam logic [4:0] OpAddib = 5'b00011;
  localparam logic [4:0] OpAdc   = 5'b00100;
  localparam logic [4:0] OpAdci  = 5'b00101;
  localparam logic [4:0] OpAddi  = 5'b00110;
  localparam logic [4:0] OpCmp   = 5'b00111;
  localparam logic [4:0] OpStw   = 5'b01000;
  localparam logic [4:0] OpPush  = 5'b01001;
  localparam logic [4:0] OpSub   = 5'b01010;
  localparam logic [4:0] OpSubib = 5'b01011;
  localparam logic [4:0] OpSuc   = 5'b01100;
  localparam logic [4:0] OpSuci  = 5'b01101;
  localparam logic [4:0] OpSubi  = 5'b01110;
  localparam logic [4:0] OpCmpi  = 5'b01111;
  localparam logic [4:0] OpAnd   = 5'b10000;
  localparam logic [4:0] OpOr    = 5'b10001;
  localparam logic [4:0] OpNot   = 5'b10010;
  localparam logic [4:0] OpXor   = 5'b10011;
  localparam logic [4:0] OpLui   = 5'b10100;
  localparam logic [4:0] OpLli   = 5'b10101;
  localparam logic [4:0] OpNand  = 5'b10110;
  localparam logic [4:0] OpNor   = 5'b10111;
  localparam logic [4:0] OpIntr  = 5'b11001;
  localparam logic [4:0] OpNeg   = 5'b11010;
  localparam logic [4:0] OpAsr   = 5'b11100;
  localparam logic [4:0] OpLsr   = 5'b11101;
  localparam logic [4:0] OpBr    = 5'b11110;
  localparam logic [4:0] OpLsl   = 5'b11111;

  localparam logic [2:0] CondJmp = 3'b001;
  localparam logic [2:0] CondRet = 3'b010;
  localparam logic [2:0] CondBwl = 3'b011;
  localparam logic [2:0] CondBlt = 3'b100;
  localparam logic [2:0] CondBge = 3'b101;
  localparam logic [2:0] CondBne = 3'b110;
  localparam logic [2:0] CondBe  = 3'b111;

  localparam logic [2:0] SubReti = 3'd0;
  localparam logic [2:0] SubEnai = 3'd1;
  localparam logic [2:0] SubDisi = 3'd2;
  localparam logic [2:0] SubLdf  = 3'd3;
  localparam logic [2:0] SubStf  = 3'd4;

  state_e     r_state, w_state_d;
  logic       r_int_en, w_int_en_d;
  logic       r_fetch_first;
  logic [4:0] w_opcode;
  logic [2:0] w_cond;
  logic [2:0] w_sub;
  logic       w_flag_z, w_flag_v, w_flag_n;
  logic       w_taken;
  logic       w_alu_cls, w_alu_imm, w_imm_long, w_is_cmp, w_no_flags;
  logic       w_unused;

  assign w_opcode = i_instr[IW-1:IW-5];
  assign w_cond   = i_instr[IW-6:IW-8];
  assign w_sub    = i_instr[2:0];
  assign w_flag_z = i_flags[0];
  assign w_flag_v = i_flags[2];
  assign w_flag_n = i_flags[3];
  assign w_unused = ^{i_instr[IW-9:3], i_flags[1]};
  assign o_int_en = r_int_en;

  // ALU-class decode: which opcodes write Rd, take an immediate, use the long immediate
  always_comb begin
    w_alu_cls  = 1'b0;
    w_alu_imm  = 1'b0;
    w_imm_long = 1'b0;
    w_is_cmp   = 1'b0;
    w_no_flags = 1'b0;
    case (w_opcode)
      OpAdd, OpAdc, OpNeg, OpSub, OpSuc, OpAnd, OpOr, OpXor,
      OpNot, OpNand, OpNor, OpLsl, OpLsr, OpAsr: w_alu_cls = 1'b1;
      OpAddi, OpAdci, OpSubi, OpSuci: begin
        w_alu_cls = 1'b1;
        w_alu_imm = 1'b1;
      end
      OpAddib, OpSubib: begin
        w_alu_cls  = 1'b1;
        w_alu_imm  = 1'b1;
        w_imm_long = 1'b1;
      end
      OpLui, OpLli: begin
        w_alu_cls  = 1'b1;
        w_alu_imm  = 1'b1;
        w_imm_long = 1'b1;
        w_no_flags = 1'b1;
      end
      OpCmp: begin
        w_alu_cls = 1'b1;
        w_is_cmp  = 1'b1;
      end
      OpCmpi: begin
        w_alu_cls = 1'b1;
        w_alu_imm = 1'b1;
        w_is_cmp  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (w_cond)
      CondBne: w_taken = ~w_flag_z;
      CondBe:  w_taken = w_flag_z;
      CondBlt: w_taken = w_flag_n ^ w_flag_v;
      CondBge: w_taken = ~(w_flag_n ^ w_flag_v);
      default: w_taken = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= StFetch;
      r_int_en      <= 1'b0;
      r_fetch_first <= 1'b1;
    end else begin
      r_state       <= w_state_d;
      r_int_en      <= w_int_en_d;
      r_fetch_first <= (r_state != StFetch);
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_int_en_d   = r_int_en;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_ir_we      = 1'b0;
    o_pc_we      = 1'b0;
    o_reg_we     = 1'b0;
    o_lr_we      = 1'b0;
    o_flag_we    = 1'b0;
    o_pc_sel     = PcOne;
    o_op1_sel    = Op1Rd1;
    o_op2_sel    = Op2Imm;
    o_imm_sel    = ImmLong;
    o_wd_sel     = WdAlu;
    o_rs1_sel    = Rs1Rd;
    o_rw_sel     = RwRd;
    o_lr_sel     = LrSys;
    o_flag_sel   = FlagAlu;
    o_alu_or_sel = AluNone;
    o_int_ack    = 1'b0;
    // Outputs stay at their defaults while reset is held so a bus strobe drops at once
    if (!i_rst) begin
      case (r_state)
        StFetch: begin
          if (r_fetch_first && i_int_req && r_int_en) begin
            w_state_d = StIntEnt;
          end else begin
            o_mem_read = 1'b1;
            if (i_mem_rdy) begin
              o_ir_we   = 1'b1;
              o_pc_we   = 1'b1;
              w_state_d = StExec;
            end
          end
        end
        StExec: begin
          w_state_d = StFetch;
          if (w_alu_cls) begin
            o_reg_we  = ~w_is_cmp;
            o_flag_we = ~w_no_flags;
            o_op2_sel = w_alu_imm ? Op2Imm : Op2Rd2;
            o_imm_sel = w_imm_long ? ImmLong : ImmShort;
          end else begin
            case (w_opcode)
              OpLdw, OpStw: begin
                o_imm_sel = ImmShort;
                w_state_d = StMem;
              end
              OpPush: begin
                o_rs1_sel    = Rs1Seven;
                o_op2_sel    = Op2Zero;
                o_alu_or_sel = AluSub;
                o_rw_sel     = RwSeven;
                o_reg_we     = 1'b1;
                w_state_d    = StMem;
              end
              OpPop: w_state_d = StMem;
              OpBr: begin
                if (w_taken) begin
                  o_pc_we   = 1'b1;
                  o_pc_sel  = (w_cond == CondRet) ? PcLr : PcAluOut;
                  o_op1_sel = (w_cond == CondJmp) ? Op1Rd1 : Op1Pc;
                  o_imm_sel = ImmLong;
                  if (w_cond == CondBwl) begin
                    o_lr_we  = 1'b1;
                    o_lr_sel = LrPc;
                  end
                end
              end
              OpIntr: begin
                case (w_sub)
                  SubReti: begin
                    o_pc_sel   = PcLr;
                    o_pc_we    = 1'b1;
                    w_int_en_d = 1'b1;
                  end
                  SubEnai: w_int_en_d = 1'b1;
                  SubDisi: w_int_en_d = 1'b0;
                  SubLdf: begin
                    o_flag_we  = 1'b1;
                    o_flag_sel = FlagSys;
                  end
                  SubStf: begin
                    o_reg_we = 1'b1;
                    o_wd_sel = WdSys;
                  end
                  default: ;
                endcase
              end
              default: ;
            endcase
          end
        end
        StMem: begin
          case (w_opcode)
            OpLdw: begin
              o_imm_sel  = ImmShort;
              o_mem_read = 1'b1;
              if (i_mem_rdy) begin
                o_reg_we  = 1'b1;
                o_wd_sel  = WdSys;
                w_state_d = StFetch;
              end
            end
            OpStw: begin
              o_imm_sel   = ImmShort;
              o_mem_write = 1'b1;
              if (i_mem_rdy) w_state_d = StFetch;
            end
            OpPush: begin
              o_rs1_sel   = Rs1Seven;
              o_op2_sel   = Op2Zero;
              o_mem_write = 1'b1;
              if (i_mem_rdy) w_state_d = StFetch;
            end
            OpPop: begin
              o_rs1_sel  = Rs1Seven;
              o_op2_sel  = Op2Zero;
              o_mem_read = 1'b1;
              if (i_mem_rdy) begin
                o_reg_we  = 1'b1;
                o_wd_sel  = WdSys;
                w_state_d = StSpUpd;
              end
            end
            default: w_state_d = StFetch;
          endcase
        end
        StSpUpd: begin
          o_rs1_sel    = Rs1Seven;
          o_op2_sel    = Op2Zero;
          o_alu_or_sel = AluAdd;
          o_rw_sel     = RwSeven;
          o_reg_we     = 1'b1;
          w_state_d    = StFetch;
        end
        StIntEnt: begin
          o_lr_we    = 1'b1;
          o_lr_sel   = LrPc;
          o_pc_we    = 1'b1;
          o_pc_sel   = PcInt;
          o_int_ack  = 1'b1;
          w_int_en_d = 1'b0;
          w_state_d  = StFetch;
        end
        default: w_state_d = StFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench for cpu_control_fsm: a per-instruction reference model queues the
// expected control vector for every cycle; an independent monitor compares each cycle.
module tb_cpu_control_fsm;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       ir_we;
    logic       pc_we;
    logic       reg_we;
    logic       lr_we;
    logic       flag_we;
    logic [2:0] pc_sel;
    logic       op1_sel;
    logic [1:0] op2_sel;
    logic       imm_sel;
    logic       wd_sel;
    logic [1:0] rs1_sel;
    logic [1:0] rw_sel;
    logic       lr_sel;
    logic       flag_sel;
    logic [1:0] alu_or_sel;
    logic       int_ack;
    logic       int_en;
  } ctl_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] instr = '0;
  logic [3:0] flags = '0;
  logic mem_rdy = 1'b0;
  logic int_req = 1'b0;
  logic mem_read, mem_write, ir_we, pc_we, reg_we, lr_we, flag_we;
  logic [2:0] pc_sel;
  logic op1_sel, imm_sel, wd_sel, lr_sel, flag_sel, int_ack, int_en;
  logic [1:0] op2_sel, rs1_sel, rw_sel, alu_or_sel;

  always #5 clk = ~clk;

  cpu_control_fsm #(.IW(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_instr(instr), .i_flags(flags), .i_mem_rdy(mem_rdy),
    .i_int_req(int_req), .o_mem_read(mem_read), .o_mem_write(mem_write), .o_ir_we(ir_we),
    .o_pc_we(pc_we), .o_reg_we(reg_we), .o_lr_we(lr_we), .o_flag_we(flag_we),
    .o_pc_sel(pc_sel), .o_op1_sel(op1_sel), .o_op2_sel(op2_sel), .o_imm_sel(imm_sel),
    .o_wd_sel(wd_sel), .o_rs1_sel(rs1_sel), .o_rw_sel(rw_sel), .o_lr_sel(lr_sel),
    .o_flag_sel(flag_sel), .o_alu_or_sel(alu_or_sel), .o_int_ack(int_ack), .o_int_en(int_en)
  );

  ctl_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_pass = 0;
  bit    mon_en = 1'b0;
  bit    m_int_en = 1'b0;
  string cur_tag = "reset";

  // Instruction-set tables, filled from mnemonic opcode lists
  bit alu_reg[32], alu_imm[32], imm_long[32], no_flags[32], is_cmp[32];

  function automatic void init_tables();
    logic [4:0] reg_ops[15] = '{5'b00010, 5'b00100, 5'b11010, 5'b01010, 5'b01100, 5'b10000,
                                5'b10001, 5'b10011, 5'b10010, 5'b10110, 5'b10111, 5'b11111,
                                5'b11101, 5'b11100, 5'b00111};
    logic [4:0] imm_ops[9] = '{5'b00110, 5'b00011, 5'b00101, 5'b01110, 5'b01011, 5'b01101,
                               5'b10100, 5'b10101, 5'b01111};
    foreach (reg_ops[i]) alu_reg[reg_ops[i]] = 1'b1;
    foreach (imm_ops[i]) alu_imm[imm_ops[i]] = 1'b1;
    imm_long[5'b00011] = 1'b1;
    imm_long[5'b01011] = 1'b1;
    imm_long[5'b10100] = 1'b1;
    imm_long[5'b10101] = 1'b1;
    no_flags[5'b10100] = 1'b1;
    no_flags[5'b10101] = 1'b1;
    is_cmp[5'b00111]   = 1'b1;
    is_cmp[5'b01111]   = 1'b1;
  endfunction

  function automatic ctl_t dflt();
    ctl_t e;
    e = '0;
    e.rw_sel   = 2'b01;
    e.flag_sel = 1'b1;
    return e;
  endfunction

  // Monitor: every cycle the DUT presents a control vector; pop and compare.
  ctl_t  act, expv;
  string tagv;
  always @(negedge clk) begin
    if (mon_en) begin
      act = {mem_read, mem_write, ir_we, pc_we, reg_we, lr_we, flag_we, pc_sel, op1_sel,
             op2_sel, imm_sel, wd_sel, rs1_sel, rw_sel, lr_sel, flag_sel, alu_or_sel,
             int_ack, int_en};
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL underflow: got %b, no expectation queued", act);
      end else begin
        expv = exp_q.pop_front();
        tagv = tag_q.pop_front();
        if (act === expv) n_pass++;
        else $display("FAIL %s instr=%h: got %b want %b", tagv, instr, act, expv);
      end
    end
  end

  task automatic step(input ctl_t e, input logic rdy);
    mem_rdy  = rdy;
    e.int_en = m_int_en;
    exp_q.push_back(e);
    tag_q.push_back(cur_tag);
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wait(input ctl_t e, input int waits, input ctl_t last);
    for (int w = 0; w < waits; w++) step(e, 1'b0);
    step(last, 1'b1);
  endtask

  task automatic run_instr(input logic [15:0] ins, input logic [3:0] fl, input logic irq,
                           input int fw, input int mw, input string tag);
    ctl_t e, l;
    logic [4:0] op;
    logic [2:0] cond;
    logic [2:0] sub;
    bit taken;
    cur_tag = tag;
    instr   = ins;
    flags   = fl;
    int_req = irq;
    op      = ins[15:11];
    cond    = ins[10:8];
    sub     = ins[2:0];
    if (irq && m_int_en) begin
      step(dflt(), 1'b0);
      e = dflt();
      e.lr_we = 1'b1; e.lr_sel = 1'b1; e.pc_we = 1'b1; e.pc_sel = 3'b111; e.int_ack = 1'b1;
      step(e, 1'b0);
      m_int_en = 1'b0;
    end
    e = dflt(); e.mem_read = 1'b1;
    l = e; l.ir_we = 1'b1; l.pc_we = 1'b1;
    bus_wait(e, fw, l);
    e = dflt();
    if (alu_reg[op] || alu_imm[op]) begin
      e.reg_we  = !is_cmp[op];
      e.flag_we = !no_flags[op];
      e.op2_sel = alu_imm[op] ? 2'b00 : 2'b01;
      e.imm_sel = imm_long[op] ? 1'b0 : 1'b1;
      step(e, 1'b0);
    end else if (op == 5'b00000 || op == 5'b01000) begin
      e.imm_sel = 1'b1;
      step(e, 1'b0);
      if (op == 5'b00000) e.mem_read = 1'b1;
      else e.mem_write = 1'b1;
      l = e;
      if (op == 5'b00000) begin l.reg_we = 1'b1; l.wd_sel = 1'b1; end
      bus_wait(e, mw, l);
    end else if (op == 5'b01001) begin
      e.rs1_sel = 2'b10; e.op2_sel = 2'b10; e.alu_or_sel = 2'b11; e.rw_sel = 2'b10;
      e.reg_we = 1'b1;
      step(e, 1'b0);
      e = dflt(); e.rs1_sel = 2'b10; e.op2_sel = 2'b10; e.mem_write = 1'b1;
      bus_wait(e, mw, e);
    end else if (op == 5'b00001) begin
      step(e, 1'b0);
      e.rs1_sel = 2'b10; e.op2_sel = 2'b10; e.mem_read = 1'b1;
      l = e; l.reg_we = 1'b1; l.wd_sel = 1'b1;
      bus_wait(e, mw, l);
      e = dflt(); e.rs1_sel = 2'b10; e.op2_sel = 2'b10; e.alu_or_sel = 2'b10;
      e.rw_sel = 2'b10; e.reg_we = 1'b1;
      step(e, 1'b0);
    end else if (op == 5'b11110) begin
      if (cond == 3'd6) taken = !fl[0];
      else if (cond == 3'd7) taken = fl[0];
      else if (cond == 3'd4) taken = fl[3] != fl[2];
      else if (cond == 3'd5) taken = fl[3] == fl[2];
      else taken = 1'b1;
      if (taken) begin
        e.pc_we = 1'b1;
        e.pc_sel = (cond == 3'd2) ? 3'b011 : 3'b001;
        e.op1_sel = (cond == 3'd1) ? 1'b0 : 1'b1;
        if (cond == 3'd3) begin e.lr_we = 1'b1; e.lr_sel = 1'b1; end
      end
      step(e, 1'b0);
    end else if (op == 5'b11001) begin
      if (sub == 3'd0) begin e.pc_we = 1'b1; e.pc_sel = 3'b011; end
      if (sub == 3'd3) begin e.flag_we = 1'b1; e.flag_sel = 1'b0; end
      if (sub == 3'd4) begin e.reg_we = 1'b1; e.wd_sel = 1'b1; end
      step(e, 1'b0);
      if (sub == 3'd0 || sub == 3'd1) m_int_en = 1'b1;
      if (sub == 3'd2) m_int_en = 1'b0;
    end else begin
      step(e, 1'b0);
    end
  endtask

  task automatic mid_fetch_reset();
    ctl_t e;
    cur_tag = "reset_mid_fetch";
    int_req = 1'b0;
    e = dflt(); e.mem_read = 1'b1;
    step(e, 1'b0);
    rst = 1'b1;
    m_int_en = 1'b0;
    step(dflt(), 1'b0);
    step(dflt(), 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] ri;
    init_tables();
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    step(dflt(), 1'b0);
    step(dflt(), 1'b0);
    rst = 1'b0;
    run_instr(16'h3000, 4'h0, 1'b0, 2, 0, "addi");
    run_instr(16'hF600, 4'b0001, 1'b0, 0, 0, "bne_z1");
    run_instr(16'hF600, 4'b0000, 1'b0, 1, 0, "bne_z0");
    run_instr(16'hF300, 4'h0, 1'b0, 0, 0, "bwl");
    run_instr(16'h4800, 4'h0, 1'b0, 0, 0, "push");
    run_instr(16'h0800, 4'h0, 1'b0, 0, 0, "pop");
    run_instr(16'h0000, 4'h0, 1'b0, 0, 2, "ldw");
    run_instr(16'h4000, 4'h0, 1'b0, 1, 1, "stw");
    run_instr(16'hC801, 4'h0, 1'b1, 0, 0, "enai");
    run_instr(16'h1000, 4'h0, 1'b1, 0, 0, "irq_entry");
    run_instr(16'hC800, 4'h0, 1'b1, 0, 0, "reti");
    run_instr(16'h1000, 4'h0, 1'b1, 1, 0, "irq_after_reti");
    run_instr(16'hC000, 4'h0, 1'b0, 0, 0, "undef");
    run_instr(16'hC801, 4'h0, 1'b0, 0, 0, "enai2");
    mid_fetch_reset();
    run_instr(16'h1000, 4'h0, 1'b1, 0, 0, "after_reset");
    for (int i = 0; i < 400; i++) begin
      ri = 16'($urandom);
      if ($urandom_range(3) == 0) ri = {5'b11001, ri[10:3], 3'($urandom_range(7))};
      run_instr(ri, 4'($urandom), ($urandom_range(2) == 0), $urandom_range(3),
                $urandom_range(3), "random");
      if (i == 200) mid_fetch_reset();
    end
    mon_en = 1'b0;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d leftover expectations, want 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
